fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage and F/D pipeline latch of the pipelined processor. It owns the program counter and drives the instruction-memory address. It absorbs the one-cycle read latency of the synchronous block-RAM instruction memory. It presents a registered instruction, its PC and PC+1 to the decode stage (`instr_decode`), honouring decode-stall and execute-redirect (branch/jump flush) requests without losing or duplicating instructions.

## Interface
- `RESET_PC`, default 0: PC value loaded on reset (word address).
- `ADDR_WIDTH`, default 12: instruction-memory address width.

- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: decode cannot accept; hold F/D contents.
- `redirect` in 1: taken branch/jump resolved downstream; flush and refetch.
- `redirect_pc` in 32: target word address, sampled when `redirect`=1.
- `address_imem` out ADDR_WIDTH: instruction-memory read address.
- `q_imem` in 32: instruction-memory data, valid the cycle after the corresponding `address_imem`.
- `fd_instr` out 32: instruction to decode; 32'h0 (NOP) when invalid.
- `fd_pc` out 32: word address of `fd_instr`.
- `fd_pc_plus1` out 32: `fd_pc`+1, registered.
- `fd_valid` out 1: F/D holds a real instruction.

## Operation
- Internal state:
  - `pc` (32): next address to request.
  - `req_valid`/`req_pc`: the request issued last cycle whose data is on `q_imem` this cycle.
  - `skid_valid`/`skid_instr`/`skid_pc`: a one-entry hold buffer.
  - The F/D registers.
- `address_imem` = `pc[ADDR_WIDTH-1:0]`, combinational from the register. It is always driven; a read is only counted when issued.
- Per-edge priority: `reset` > `redirect` > `stall` > normal.
- Reset: `pc`<=RESET_PC; `req_valid`, `skid_valid`, `fd_valid` <= 0; `fd_instr`, `fd_pc` <= 0; `fd_pc_plus1` <= 1.
- Redirect (overrides stall):
  - `pc`<=`redirect_pc`.
  - `req_valid`<=0 and `skid_valid`<=0; in-flight data is discarded.
  - F/D <= NOP: `fd_valid`=0, `fd_instr`=0. `fd_pc` and `fd_pc_plus1` are don't-care but held.
- Stall (no redirect):
  - F/D and `pc` hold; `req_valid`<=0.
  - If `req_valid`=1 and `skid_valid`=0: `skid_instr`<=`q_imem`, `skid_pc`<=`req_pc`, `skid_valid`<=1.
  - The buffer cannot overflow, since at most one request is in flight when a stall begins.
- Normal:
  - Issue: `req_pc`<=`pc`, `req_valid`<=1, `pc`<=`pc`+1.
  - F/D load, first match wins:
    - If `skid_valid`: F/D<=skid contents and `skid_valid`<=0.
    - Else if `req_valid`: F/D<={`q_imem`, `req_pc`} and `fd_valid`<=1.
    - Else: F/D<=NOP with `fd_valid`=0.
- `fd_pc_plus1` is loaded with the source PC + 1 whenever `fd_pc` loads.
- Arithmetic: 32-bit unsigned, wraps 32'hFFFFFFFF -> 0. The address is truncation of `pc`.
- Instruction order into F/D is strictly program order. No instruction may be dropped or repeated except the flushed wrong-path ones.

## Timing
- Fetch-to-decode latency is 2 edges. An address issued before edge N (captured into `req` at N) appears in F/D after edge N+1.
- After reset deasserts before edge 0:
  - Edge 0 issues RESET_PC.
  - Edge 1 loads it into F/D (`fd_valid`=1).
  - Thereafter one instruction per cycle.
- Redirect sampled at edge R:
  - `fd_valid`=0 after R and R+1.
  - The instruction at `redirect_pc` is in F/D after R+2; its successor follows after R+3.
- Stall held for edges S..S+k-1:
  - F/D is constant throughout.
  - The first unstalled edge loads the skid entry, or a bubble if none was in flight.
  - The next edge loads the new fetch. No bubble is inserted when the skid was filled.
- Stall asserted during a redirect bubble: no capture (`req_valid`=0); F/D stays NOP.
- Reset mid-stall or mid-redirect: reset wins and clears all valids and the skid.

## Test plan
- Reset with RESET_PC=0 and imem[i]=32'hA000_0000+i, stall/redirect low: after edge 1, `fd_pc`=0, `fd_instr`=A0000000, `fd_pc_plus1`=1; then PCs 1,2,3... on consecutive edges, `fd_valid` steady 1.
- Stall for 3 cycles while F/D holds pc=4:
  - F/D stays pc=4 for 3 cycles; `address_imem` frozen.
  - Release gives pc=5 from skid, then pc=6, 7 with no gap or duplicate.
- Redirect to 32'h40 while F/D holds pc=7: `fd_valid`=0 for two edges, then `fd_pc`=40 with `fd_instr`=imem[40], then 41.
- Redirect and stall asserted together: redirect wins; F/D becomes NOP and the skid is cleared; after release, pc=`redirect_pc` is delivered with no stale instruction.
- Stall asserted on the edge after a redirect (no request in flight): bubble persists during the stall; after release, F/D gets a bubble then `redirect_pc`.
- Redirect to 32'hFFFF_FFFF with ADDR_WIDTH=12: `address_imem`=12'hFFF, then 12'h000; `fd_pc` shows FFFFFFFF then 0; `fd_pc_plus1` for FFFFFFFF is 0.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, tracks the one-cycle imem read, and feeds the F/D latch
// through a one-entry skid buffer so stalls and redirects never drop or repeat work.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic [ADDR_WIDTH-1:0] address_imem,
  input  logic [31:0]           q_imem,
  output logic [31:0]           fd_instr,
  output logic [31:0]           fd_pc,
  output logic [31:0]           fd_pc_plus1,
  output logic                  fd_valid
);
  logic [31:0] pc, req_pc, skid_instr, skid_pc, src_pc;
  logic        req_valid, skid_valid;
  assign address_imem = pc[ADDR_WIDTH-1:0];
  assign src_pc = skid_valid ? skid_pc : req_pc;
  always_ff @(posedge clock) begin
    if (reset) begin
      pc          <= RESET_PC;
      req_valid   <= 1'b0;
      req_pc      <= 32'h0;
      skid_valid  <= 1'b0;
      skid_instr  <= 32'h0;
      skid_pc     <= 32'h0;
      fd_valid    <= 1'b0;
      fd_instr    <= 32'h0;
      fd_pc       <= 32'h0;
      fd_pc_plus1 <= 32'h1;
    end else if (redirect) begin
      pc         <= redirect_pc;
      req_valid  <= 1'b0;
      skid_valid <= 1'b0;
      fd_valid   <= 1'b0;
      fd_instr   <= 32'h0;
    end else if (stall) begin
      req_valid <= 1'b0;
      // the returning read must be caught now or it is lost
      if (req_valid && !skid_valid) begin
        skid_valid <= 1'b1;
        skid_instr <= q_imem;
        skid_pc    <= req_pc;
      end
    end else begin
      req_pc     <= pc;
      req_valid  <= 1'b1;
      pc         <= pc + 32'd1;
      skid_valid <= 1'b0;
      fd_valid   <= skid_valid | req_valid;
      fd_instr   <= skid_valid ? skid_instr : req_valid ? q_imem : 32'h0;
      if (skid_valid || req_valid) begin
        fd_pc       <= src_pc;
        fd_pc_plus1 <= src_pc + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed vectors against a synchronous imem holding A000_0000+addr.
module tb_fetch_stage;
  logic        clock = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [11:0] address_imem;
  logic [31:0] q_imem = 32'h0;
  logic [31:0] fd_instr, fd_pc, fd_pc_plus1;
  logic        fd_valid;
  int          n_checks = 0;
  int          n_fail = 0;

  fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .address_imem(address_imem), .q_imem(q_imem),
    .fd_instr(fd_instr), .fd_pc(fd_pc), .fd_pc_plus1(fd_pc_plus1), .fd_valid(fd_valid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) q_imem <= 32'hA000_0000 + {20'h0, address_imem};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fd(input string tag, input logic v, input logic [31:0] pc);
    logic [11:0] a;
    a = pc[11:0];
    check({tag, ".valid"}, {31'h0, fd_valid}, {31'h0, v});
    check({tag, ".instr"}, fd_instr, v ? 32'hA000_0000 + {20'h0, a} : 32'h0);
    if (v) begin
      check({tag, ".pc"}, fd_pc, pc);
      check({tag, ".pc1"}, fd_pc_plus1, pc + 32'd1);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    check("rst.valid", {31'h0, fd_valid}, 32'h0);
    check("rst.instr", fd_instr, 32'h0);
    check("rst.pc", fd_pc, 32'h0);
    check("rst.pc1", fd_pc_plus1, 32'h1);
    check("rst.addr", {20'h0, address_imem}, 32'h0);
    reset = 1'b0;
    tick();
    fd("e0", 1'b0, 32'h0);
    for (int i = 0; i <= 4; i++) begin
      tick();
      fd($sformatf("seq%0d", i), 1'b1, i);
    end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      fd($sformatf("stall%0d", i), 1'b1, 32'd4);
      check($sformatf("stall%0d.addr", i), {20'h0, address_imem}, 32'd6);
    end
    stall = 1'b0;
    for (int i = 5; i <= 7; i++) begin
      tick();
      fd($sformatf("rel%0d", i), 1'b1, i);
    end
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    fd("rd0", 1'b0, 32'h0);
    check("rd0.addr", {20'h0, address_imem}, 32'h40);
    tick();
    fd("rd1", 1'b0, 32'h0);
    tick();
    fd("rd2", 1'b1, 32'h40);
    tick();
    fd("rd3", 1'b1, 32'h41);
    stall = 1'b1;
    tick();
    fd("sk", 1'b1, 32'h41);
    redirect = 1'b1; redirect_pc = 32'h80;
    tick();
    redirect = 1'b0;
    fd("rs0", 1'b0, 32'h0);
    tick();
    fd("rs1", 1'b0, 32'h0);
    stall = 1'b0;
    tick();
    fd("rs2", 1'b0, 32'h0);
    tick();
    fd("rs3", 1'b1, 32'h80);
    tick();
    fd("rs4", 1'b1, 32'h81);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    check("wr.addr0", {20'h0, address_imem}, 32'hFFF);
    tick();
    check("wr.addr1", {20'h0, address_imem}, 32'h0);
    tick();
    fd("wr0", 1'b1, 32'hFFFF_FFFF);
    check("wr0.pc1", fd_pc_plus1, 32'h0);
    tick();
    fd("wr1", 1'b1, 32'h0);
    stall = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    fd("mrst", 1'b0, 32'h0);
    check("mrst.pc", fd_pc, 32'h0);
    check("mrst.pc1", fd_pc_plus1, 32'h1);
    check("mrst.addr", {20'h0, address_imem}, 32'h0);
    tick();
    fd("mrst.e0", 1'b0, 32'h0);
    tick();
    fd("mrst.e1", 1'b1, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
